// File: rtl/ucsbece154_mem_pkg.sv
// Shared definitions for the main-memory arbiter, the caches and the memory model.
// Holds the default burst length, the arbiter state encoding and the
// block-alignment helper used when forwarding a miss address.
package ucsbece154_mem_pkg;

    // Words per burst; the caches and the memory model use the same value.
    localparam int BLOCK_WORDS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        BURST = 2'b11
    } arb_state_t;

    // Clear the byte-offset bits of an address so it points at the start of its block.
    function automatic logic [31:0] block_align(input logic [31:0] addr, input int offset_bits);
        logic [31:0] mask;
        mask = ~((32'd1 << offset_bits) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/ucsbece154_rr_arb2.sv
// Two-way round-robin pick. A lone requester always wins; on a tie the
// requester that was not served last time wins. Purely combinational; the
// caller owns the last-grant pointer.
module ucsbece154_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // One-hot winner selection from the request vector and the pointer.
    always_comb begin
        grant_o = 2'b00;
        if (req_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = req_i;
        end
    end

endmodule

// File: rtl/ucsbece154_mem_arbiter.sv
// Arbiter and burst sequencer for the shared burst-read main-memory port.
// Requester 0 is the icache refill path, requester 1 the dcache refill path.
// One ReadRequest is issued per grant and the returned burst is steered to
// the granted requester with a beat index and a last-beat done pulse.
module ucsbece154_mem_arbiter
    import ucsbece154_mem_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
    parameter int OFFSET_BITS = $clog2(BLOCK_WORDS) + 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     req_i,
    input  logic [31:0]                    addr0_i,
    input  logic [31:0]                    addr1_i,
    output logic [1:0]                     grant_o,
    output logic [31:0]                    rdata_o,
    output logic [1:0]                     rvalid_o,
    output logic [$clog2(BLOCK_WORDS)-1:0] rbeat_o,
    output logic [1:0]                     done_o,
    output logic                           mem_ReadRequest_o,
    output logic [31:0]                    mem_ReadAddress_o,
    input  logic [31:0]                    mem_DataIn_i,
    input  logic                           mem_DataReady_i
);

    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    arb_state_t        state_reg;
    logic [1:0]        grant_reg;
    logic              last_grant_reg;
    logic [31:0]       addr_q;
    logic              mem_req_reg;
    logic [BEAT_W-1:0] beat_reg;

    logic [1:0]        pick;
    logic [31:0]       sel_addr;
    logic              beat_fire;
    logic              last_fire;

    ucsbece154_rr_arb2 u_rr_arb2 (
        .req_i        (req_i),
        .last_grant_i (last_grant_reg),
        .grant_o      (pick)
    );

    assign sel_addr = pick[1] ? addr1_i : addr0_i;

    // A beat is delivered in WAIT or BURST whenever the memory presents data;
    // WAIT and BURST behave identically on a data cycle.
    assign beat_fire = ((state_reg == WAIT) || (state_reg == BURST)) && mem_DataReady_i;
    assign last_fire = beat_fire && (beat_reg == LAST_BEAT);

    // Per-requester steering of the beat-valid and done strobes.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_route
            assign rvalid_o[gi] = beat_fire & grant_reg[gi];
            assign done_o[gi]   = last_fire & grant_reg[gi];
        end
    endgenerate

    // Shared data bus is zero outside valid beats so requesters never see X.
    assign rdata_o           = beat_fire ? mem_DataIn_i : 32'd0;
    assign rbeat_o           = beat_reg;
    assign grant_o           = grant_reg;
    assign mem_ReadRequest_o = mem_req_reg;
    // addr_q is only reloaded on a new grant, so it holds through the whole
    // transaction and afterwards; it is zero only after reset.
    assign mem_ReadAddress_o = addr_q;

    // Arbitration / issue / burst-tracking state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= 2'b00;
            last_grant_reg <= 1'b1;
            addr_q         <= 32'd0;
            mem_req_reg    <= 1'b0;
            beat_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_i) begin
                        // Request and address are registered together so the
                        // memory sees both in the ISSUE cycle.
                        grant_reg      <= pick;
                        last_grant_reg <= pick[1];
                        addr_q         <= block_align(sel_addr, OFFSET_BITS);
                        mem_req_reg    <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_req_reg <= 1'b0;
                    state_reg   <= WAIT;
                end
                WAIT, BURST: begin
                    // A missing DataReady mid-burst simply holds the counter.
                    if (mem_DataReady_i) begin
                        if (beat_reg == LAST_BEAT) begin
                            beat_reg  <= '0;
                            grant_reg <= 2'b00;
                            state_reg <= IDLE;
                        end else begin
                            beat_reg  <= beat_reg + BEAT_W'(1);
                            state_reg <= BURST;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ucsbece154_mem_arbiter.md
Name: ucsbece154_mem_arbiter

Overview:
- Two-requester arbiter and burst sequencer for the single shared burst-read main-memory port.
- Port 0 is the instruction-cache refill path; port 1 is the data-cache refill path.
- Accepts block-refill requests, grants the memory round-robin, and issues one ReadRequest per grant.
- Routes the BLOCK_WORDS-beat burst back to the granted requester with a beat index and a completion pulse.

Parameters:
- BLOCK_WORDS, 4, words per burst; must equal the memory and cache setting; power of two, at least 2.
- OFFSET_BITS, $clog2(BLOCK_WORDS)+2, byte-offset bits cleared from the forwarded address.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_i  in  2  per-requester refill request (level); bit0 = icache, bit1 = dcache
- addr0_i  in  32  requester 0 miss address
- addr1_i  in  32  requester 1 miss address
- grant_o  out  2  one-hot; high for the whole transaction of the granted requester
- rdata_o  out  32  burst word, shared by both requesters
- rvalid_o  out  2  one-hot; beat valid for the granted requester
- rbeat_o  out  $clog2(BLOCK_WORDS)  index of the current beat within the block
- done_o  out  2  one-hot, single-cycle pulse coincident with the last beat
- mem_ReadRequest_o  out  1  to the memory ReadRequest
- mem_ReadAddress_o  out  32  to the memory ReadAddress
- mem_DataIn_i  in  32  from the memory DataIn
- mem_DataReady_i  in  1  from the memory DataReady

Behaviour:
- Reset values:
  - State IDLE; grant_o=0, rvalid_o=0, done_o=0, rbeat_o=0, mem_ReadRequest_o=0, mem_ReadAddress_o=0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
- States: IDLE, ISSUE, WAIT, BURST.
- IDLE:
  - If any req_i bit is set, select the winner: the only requester, or on a tie the one not equal to last_grant.
  - Register the winner in grant_o and update last_grant.
  - Latch its address with the low OFFSET_BITS cleared into addr_q, then go to ISSUE.
  - No request: stay in IDLE.
  - Arbitration decision to ISSUE takes exactly 1 cycle.
- ISSUE:
  - For exactly one cycle, drive mem_ReadRequest_o=1 and mem_ReadAddress_o=addr_q.
  - Both outputs are registered, so address and request are valid in the same cycle, which the memory requires.
  - Next state WAIT.
- mem_ReadAddress_o holds addr_q in every state from ISSUE until the return to IDLE; it is 0 only after reset.
- WAIT:
  - Hold until mem_DataReady_i=1.
  - On that cycle: move to BURST behaviour for the same cycle, count beat 0, rbeat_o=0.
- BURST:
  - Every cycle with mem_DataReady_i=1:
    - rvalid_o = grant_o (combinational), rdata_o = mem_DataIn_i (combinational passthrough).
    - rbeat_o = beat counter; the counter increments.
  - On beat BLOCK_WORDS-1: done_o = grant_o (combinational), counter wraps to 0.
  - The next cycle: state returns to IDLE and grant_o clears.
  - If mem_DataReady_i drops mid-burst (not expected from memory), hold the counter and assert no rvalid.
- Back-to-back:
  - A pending request may win in the IDLE cycle right after done.
  - Its ISSUE follows one cycle later; the memory has then already returned to idle.
- Requester drops req_i mid-transaction: ignored; the burst completes and is delivered.
  - Requesters must hold req_i until done_o. The winner's req may stay high; it is re-arbitrated fairly.
- rdata_o when no beat is valid: forced to 0, never X.
- Reset asserted mid-transaction: synchronous return to the reset values next cycle.
  - The memory shares the reset, so no orphaned burst remains.
- Latency from request to first beat = 1 (arb) + 1 (issue) + memory T0_DELAY + 1.

Decomposition:
- Shared package ucsbece154_mem_pkg:
  - State encoding localparams IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, BURST=2'b11.
  - BLOCK_WORDS default shared with the cache and memory.
- Sub-module ucsbece154_rr_arb2: combinational 2-way round-robin pick (req, last_grant -> one-hot grant).
  - The top level holds the pointer and the FSM.

Test Plan:
- Single request: req_i=01, addr0_i=0x0001_0014 -> mem_ReadRequest_o pulses once with address 0x0001_0010.
  - Beats then arrive with rvalid_o=01, rbeat_o=0,1,2,3, matching TEXT words 4..7.
  - done_o=01 on beat 3; grant_o clears the next cycle.
- Simultaneous requests from reset: req_i=11 -> requester 0 served first.
  - Requester 1 is granted in the IDLE cycle after done, and its ReadRequest follows one cycle later.
- Fairness: both requests held for 4 transactions -> grants alternate 0,1,0,1; no requester is ever served twice in a row.
- Mid-burst reset: assert reset at beat 2 -> all outputs zero next cycle.
  - A new req_i=10 afterwards completes a full 4-beat burst correctly.
- Request drop: deassert req_i[1] during WAIT -> the burst still completes with 4 rvalid_o=10 beats and done_o=10.
- Address bounds: addr1_i=0x0001_00FC (last TEXT block) -> issued address 0x0001_00F0; rbeat 3 returns TEXT[63].
